// File: rtl/rle_line_decoder_if.sv
// Pixel-link bundle: serial input, dav_/rfd pixel handshake and sticky status flags.
// The decoder side uses the master modport; a line consumer or bench uses slave.
interface rle_line_decoder_if;
  logic rxd;
  logic colore;
  logic endline;
  logic dav_;
  logic rfd;
  logic ovr;
  logic err;

  modport master (
    input  rxd,
    input  rfd,
    output colore,
    output endline,
    output dav_,
    output ovr,
    output err
  );

  modport slave (
    output rxd,
    output rfd,
    input  colore,
    input  endline,
    input  dav_,
    input  ovr,
    input  err
  );
endinterface

// File: rtl/rle_line_decoder.sv
// Run-length line decoder: 1-bit-per-clock frame receiver, small byte FIFO and a
// pixel emitter that expands each run into dav_/rfd handshakes.
module rle_line_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic                clock,
  input  logic                reset_,
  rle_line_decoder_if.master  bus
);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP, R_WAIT} rx_state_t;
  typedef enum logic [1:0] {O_IDLE, O_PRES, O_WACK, O_WREL} out_state_t;

  rx_state_t        r_rx_state, w_rx_next;
  out_state_t       r_out_state, w_out_next;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_colore, r_endline, r_dav_n, r_ovr, r_err;
  logic [6:0]       r_remaining;

  logic             w_push_req, w_push, w_pop, w_full, w_empty, w_frame_err;
  logic [7:0]       w_head;

  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  // 0x01 would be a colour-1 run of zero pixels, so it is rejected like a framing error.
  assign w_push_req  = (r_rx_state == R_STOP) && bus.rxd && (r_shift != 8'h01);
  assign w_frame_err = (r_rx_state == R_STOP) && (!bus.rxd || (r_shift == 8'h01));
  assign w_pop       = (r_out_state == O_IDLE) && !w_empty && bus.rfd;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign w_push      = w_push_req && (!w_full || w_pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (!bus.rxd) w_rx_next = R_DATA;
      R_DATA:  if (r_bit_cnt == 3'd7) w_rx_next = R_STOP;
      R_STOP:  w_rx_next = bus.rxd ? R_IDLE : R_WAIT;
      R_WAIT:  if (bus.rxd) w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_rx_state <= R_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ovr      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (r_rx_state == R_IDLE) r_bit_cnt <= '0;
      if (r_rx_state == R_DATA) begin
        r_shift   <= {bus.rxd, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_frame_err)            r_err <= 1'b1;
      if (w_push_req && !w_push)  r_ovr <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; occupancy is tracked by the reset pointers.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      O_IDLE:  if (w_pop) w_out_next = O_PRES;
      O_PRES:  w_out_next = O_WACK;
      O_WACK:  if (!bus.rfd) w_out_next = O_WREL;
      O_WREL:  if (bus.rfd) w_out_next = (r_remaining > 7'd1) ? O_PRES : O_IDLE;
      default: w_out_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_out_state <= O_IDLE;
      r_colore    <= 1'b0;
      r_endline   <= 1'b0;
      r_dav_n     <= 1'b1;
      r_remaining <= '0;
    end else begin
      r_out_state <= w_out_next;
      if (w_pop) begin
        // An end-of-line token is emitted as a single colour-0 transfer.
        r_colore    <= (w_head == 8'h00) ? 1'b0 : w_head[0];
        r_endline   <= (w_head == 8'h00);
        r_remaining <= (w_head == 8'h00) ? 7'd1 : w_head[7:1];
      end
      if (r_out_state == O_PRES)              r_dav_n <= 1'b0;
      if (r_out_state == O_WACK && !bus.rfd)  r_dav_n <= 1'b1;
      if (r_out_state == O_WREL && bus.rfd && r_remaining > 7'd1)
        r_remaining <= r_remaining - 7'd1;
    end
  end

  assign bus.colore  = r_colore;
  assign bus.endline = r_endline;
  assign bus.dav_    = r_dav_n;
  assign bus.ovr     = r_ovr;
  assign bus.err     = r_err;

endmodule

// File: doc/rle_line_decoder.md
Name: rle_line_decoder

Overview:
- Receiving end of the run-length pixel link: deserialises 10-bit async-style frames from a 1-bit serial line, one bit per clock.
- Decodes each frame into a run of pixels (or an end-of-line token) and hands them one at a time to a downstream consumer over a dav_/rfd handshake.
- A small byte FIFO decouples serial arrival from slow pixel consumption.

Parameters:
- FIFO_DEPTH, 4, number of decoded bytes buffered; power of 2, at least 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset_  input  1  reset, active-low, synchronous (sampled at posedge).
- rxd  input  1  serial line; idle/marking = 1.
- colore  output  1  pixel colour (0 = bianco, 1 = nero).
- endline  output  1  1 = current transfer is an end-of-line token.
- dav_  output  1  data valid, active-low.
- rfd  input  1  consumer ready-for-data; the consumer drives it low to acknowledge.
- ovr  output  1  sticky overrun flag: a byte was dropped on a full FIFO.
- err  output  1  sticky error flag: framing error or illegal byte.

Behaviour:
- Reset (reset_==0 at a posedge) applies regardless of state, including mid-frame or mid-handshake. It sets:
  - dav_=1, colore=0, endline=0, ovr=0, err=0;
  - FIFO empty; both FSMs to their idle states.
  - Partial frames and runs are discarded.
- Frame format (LSB first, 1 bit per clock, no oversampling):
  - start bit 0, then D0..D7, then stop bit 1.
  - D0 = colour; D7:D1 = run length N (unsigned 7 bits).
  - Byte 0x00 = end-of-line token.
- Receiver FSM:
  - R_IDLE: rxd==0 -> R_DATA, bit count = 0.
  - R_DATA: shift in rxd as the MSB of an 8-bit shift register (shift right); after the 8th bit -> R_STOP.
  - R_STOP, rxd==1:
    - byte 0x01 (colour 1, N=0) is illegal: err<=1, byte discarded;
    - otherwise push to the FIFO; if the FIFO is full and no pop happens that cycle, the byte is dropped and ovr<=1;
    - -> R_IDLE.
  - R_STOP, rxd==0: err<=1, byte discarded -> R_WAIT.
  - R_WAIT: stays until rxd==1, then -> R_IDLE (resync).
  - Back-to-back frames are supported: a start bit may be sampled on the clock immediately after the stop bit.
- Push and pop in the same cycle on a full FIFO: both happen; the byte is not dropped.
- Output FSM:
  - O_IDLE: if the FIFO is non-empty and rfd==1:
    - pop the byte;
    - 0x00: colore<=0, endline<=1, remaining<=1;
    - else: colore<=D0, endline<=0, remaining<=N;
    - -> O_PRES.
  - O_PRES: dav_<=0 -> O_WACK. colore/endline are therefore stable one clock before dav_ falls.
  - O_WACK: wait rfd==0, then dav_<=1 -> O_WREL.
  - O_WREL: wait rfd==1; then if remaining>1, decrement -> O_PRES, else -> O_IDLE.
  - colore/endline hold their values between transfers.
- Run of N pixels = exactly N handshakes, all with the same colour. An end-of-line token = exactly one handshake with endline=1.
- Ordering: transfers are emitted strictly in frame-arrival order.
- Latency: stop bit sampled at edge k -> byte in FIFO after edge k -> pop at edge k+1 (if O_IDLE and rfd==1) -> dav_ low after edge k+2.
- ovr and err stay set until reset.

Test Plan:
- Reset: hold reset_=0 two clocks with rxd=1 -> dav_=1, colore=0, endline=0, ovr=0, err=0. Assert reset_=0 mid-run: dav_=1 next edge, no further transfers.
- Run frame 0x07: rxd = 0,1,1,1,0,0,0,0,0,1 with a consumer acking every transfer.
  - Expect exactly 3 handshakes with colore=1, endline=0.
  - dav_ falls 2 clocks after the stop-bit edge, then stays 1.
- End-of-line frame 0x00 -> exactly one handshake with endline=1, colore=0.
- Back-to-back frames 0x04, 0xFE, 0x00 with no idle bits between them:
  - expect 2×colour0, then 127×colour0, then 1 endline token, in order;
  - ovr=0.
- Overrun: consumer never acknowledges; send FIFO_DEPTH+2 frames of distinct values.
  - Frame 1 is popped; frames 2..5 are buffered; frame 6 is dropped and ovr=1.
  - On release, runs 1..5 appear in order and frame 6 is absent.
- Errors:
  - frame 0x07 with stop bit 0 -> err=1, no transfer;
  - rxd held 0 for 3 extra clocks, then 1, then a valid 0x05 -> 2 pixels of colour 1;
  - frame 0x01 -> err stays 1, no transfer.
